// File: rtl/id_hazard_sched.sv
// id_hazard_sched: decode-stage issue scheduler with a per-register RAW scoreboard, redirect squash and stall counter
module id_hazard_sched #(
    parameter int MAX_INFLIGHT = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter bit WB_BYPASS    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_instr,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_reg,
    input  logic        i_redirect,
    output logic        o_id_issue,
    output logic        o_id_stall,
    output logic [4:0]  o_dest_reg,
    output logic        o_dest_we,
    output logic [31:0] o_pending,
    output logic [15:0] o_stall_count
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int FW = 3;
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    state_t        r_state;
    logic [FW-1:0] r_flush;
    logic [CW-1:0] r_cnt [32];
    logic [CW-1:0] w_eff [32];
    logic [15:0]   r_stall_count;
    logic [31:0]   w_inc, w_dec;
    logic [5:0]    w_op;
    logic [4:0]    w_rs, w_rt, w_dst;
    logic          w_rs_use, w_rt_use, w_we, w_we_eff, w_hazard, w_squash, w_unused;
    assign w_op     = i_id_instr[31:26];
    assign w_rs     = i_id_instr[25:21];
    assign w_rt     = i_id_instr[20:16];
    assign w_unused = ^i_id_instr[10:6];
    always_comb begin
        w_rs_use = 1'b0;
        w_rt_use = 1'b0;
        w_we     = 1'b0;
        w_dst    = w_rt;
        case (w_op)
            6'h00: begin
                w_rs_use = 1'b1;
                w_rt_use = i_id_instr[5:0] != 6'h08;
                w_we     = i_id_instr[5:0] != 6'h08;
                w_dst    = i_id_instr[15:11];
            end
            6'h23, 6'h08, 6'h0A, 6'h0C, 6'h0D: begin
                w_rs_use = 1'b1;
                w_we     = 1'b1;
            end
            6'h2B, 6'h04, 6'h05: begin
                w_rs_use = 1'b1;
                w_rt_use = 1'b1;
            end
            6'h0F: w_we = 1'b1;
            6'h03: begin
                w_we  = 1'b1;
                w_dst = 5'd31;
            end
            default: ;
        endcase
    end
    for (genvar n = 0; n < 32; n++) begin : g_sb
        assign w_eff[n]     = (WB_BYPASS && i_wb_valid && i_wb_reg == 5'(n) && r_cnt[n] != '0)
                              ? r_cnt[n] - 1'b1 : r_cnt[n];
        assign w_inc[n]     = o_id_issue & o_dest_we & (w_dst == 5'(n));
        assign w_dec[n]     = i_wb_valid & (i_wb_reg == 5'(n)) & (r_cnt[n] != '0);
        assign o_pending[n] = r_cnt[n] != '0;
    end
    assign w_we_eff   = w_we & (w_dst != 5'd0);
    assign w_hazard   = i_id_valid & ((w_rs_use & (w_rs != 5'd0) & (w_eff[w_rs] != '0)) |
                                      (w_rt_use & (w_rt != 5'd0) & (w_eff[w_rt] != '0)) |
                                      (w_we_eff & (w_eff[w_dst] == CW'(MAX_INFLIGHT))));
    assign w_squash   = i_redirect | (r_state == FLUSH);
    assign o_id_issue = rst_n & ~w_squash & i_id_valid & ~w_hazard;
    assign o_id_stall = rst_n & ~w_squash & w_hazard;
    assign o_dest_we  = rst_n & w_we_eff;
    assign o_dest_reg = rst_n ? w_dst : 5'd0;
    assign o_stall_count = r_stall_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) r_cnt[i] <= r_cnt[i] + CW'(w_inc[i]) - CW'(w_dec[i]);
        end
    end
    // the redirect cycle is itself the first squashed slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_flush       <= '0;
            r_stall_count <= '0;
        end else begin
            if (o_id_stall && r_stall_count != 16'hFFFF) r_stall_count <= r_stall_count + 16'd1;
            if (i_redirect) begin
                r_flush <= FW'(FLUSH_CYCLES - 1);
                r_state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (r_state == FLUSH) begin
                r_flush <= r_flush - 1'b1;
                r_state <= (r_flush <= FW'(1)) ? RUN : FLUSH;
            end else begin
                r_state <= w_hazard ? STALL : RUN;
            end
        end
    end
endmodule

// File: tb/tb_id_hazard_sched.sv
// tb_id_hazard_sched: vector table, corner sequences and random run against a scoreboard model
module tb_id_hazard_sched;
    localparam int FLUSH = 2;
    localparam int MAXW  = 3;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, wb_valid = 1'b0, redirect = 1'b0;
    logic [31:0] id_instr = '0;
    logic [4:0]  wb_reg = '0;
    logic        id_issue, id_stall, dest_we;
    logic [4:0]  dest_reg;
    logic [31:0] pending;
    logic [15:0] stall_count;
    int n_tests = 0, n_fail = 0;
    int m_cnt [32];
    int m_flush, m_sc;

    id_hazard_sched #(.MAX_INFLIGHT(MAXW), .FLUSH_CYCLES(FLUSH), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_id_valid(id_valid), .i_id_instr(id_instr),
        .i_wb_valid(wb_valid), .i_wb_reg(wb_reg), .i_redirect(redirect),
        .o_id_issue(id_issue), .o_id_stall(id_stall), .o_dest_reg(dest_reg),
        .o_dest_we(dest_we), .o_pending(pending), .o_stall_count(stall_count)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_flush = 0;
        m_sc = 0;
    endtask

    function automatic void decode(input logic [31:0] ins, output logic [31:0] src, output int dst);
        int op, rs, rt, rd;
        op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        src = '0;
        dst = -1;
        if (op == 0) begin
            src[rs] = 1'b1;
            if (ins[5:0] != 6'h08) begin src[rt] = 1'b1; dst = rd; end
        end else if (op == 'h23 || op == 'h08 || op == 'h0A || op == 'h0C || op == 'h0D) begin
            src[rs] = 1'b1; dst = rt;
        end else if (op == 'h2B || op == 'h04 || op == 'h05) begin
            src[rs] = 1'b1; src[rt] = 1'b1;
        end else if (op == 'h0F) dst = rt;
        else if (op == 'h03) dst = 31;
        src[0] = 1'b0;
        if (dst == 0) dst = -1;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        for (int i = 0; i < 32; i++) p[i] = m_cnt[i] > 0;
        return p;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic wv, input logic [4:0] wr,
                        input logic rd, output logic a_issue, output logic a_stall,
                        output logic a_we, output logic [4:0] a_dest);
        logic [31:0] src;
        int dst, eff[32];
        bit haz, squash, e_issue, e_stall, dec;
        id_valid = v; id_instr = ins; wb_valid = wv; wb_reg = wr; redirect = rd;
        #1;
        decode(ins, src, dst);
        for (int i = 0; i < 32; i++) eff[i] = m_cnt[i] - ((wv && wr == 5'(i) && m_cnt[i] > 0) ? 1 : 0);
        haz = 0;
        for (int i = 0; i < 32; i++) if (src[i] && eff[i] != 0) haz = 1;
        if (dst >= 0 && eff[dst] == MAXW) haz = 1;
        haz = haz && v;
        squash = rd || m_flush > 0;
        e_issue = !squash && v && !haz;
        e_stall = !squash && haz;
        a_issue = id_issue; a_stall = id_stall; a_we = dest_we; a_dest = dest_reg;
        chk("issue", id_issue, e_issue);
        chk("stall", id_stall, e_stall);
        chk("dest_we", dest_we, dst >= 0);
        if (dst >= 0) chk("dest_reg", dest_reg, dst);
        chk("pending", pending, m_pending());
        chk("stall_count", stall_count, m_sc);
        @(posedge clk);
        dec = wv && wr != 0 && m_cnt[wr] > 0;
        if (e_issue && dst >= 0) m_cnt[dst]++;
        if (dec) m_cnt[wr]--;
        if (rd) m_flush = FLUSH - 1;
        else if (m_flush > 0) m_flush--;
        if (e_stall && m_sc < 65535) m_sc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic v; logic [31:0] ins; logic wv; logic [4:0] wr;
        logic e_issue, e_stall, e_we; logic [4:0] e_dest;
    } vec_t;
    vec_t tbl [18];

    initial begin
        logic ai, as, aw;
        logic [4:0] ad;
        logic [5:0] ops [10];
        logic [5:0] op;
        model_reset();
        id_valid = 1'b1; id_instr = 32'h20050001;
        #1;
        chk("rst_issue", id_issue, 0);
        chk("rst_stall", id_stall, 0);
        chk("rst_dest_we", dest_we, 0);
        chk("rst_pending", pending, 0);
        chk("rst_stall_count", stall_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl[0]  = '{1, 32'h20050001, 0, 5'd0,  1, 0, 1, 5'd5};
        tbl[1]  = '{1, 32'h00A53020, 0, 5'd0,  0, 1, 1, 5'd6};
        tbl[2]  = '{1, 32'h00A53020, 0, 5'd0,  0, 1, 1, 5'd6};
        tbl[3]  = '{1, 32'h00A53020, 1, 5'd5,  1, 0, 1, 5'd6};
        tbl[4]  = '{1, 32'h20070001, 0, 5'd0,  1, 0, 1, 5'd7};
        tbl[5]  = '{1, 32'h20070001, 0, 5'd0,  1, 0, 1, 5'd7};
        tbl[6]  = '{1, 32'h20070001, 0, 5'd0,  1, 0, 1, 5'd7};
        tbl[7]  = '{1, 32'h20070001, 0, 5'd0,  0, 1, 1, 5'd7};
        tbl[8]  = '{1, 32'h20070001, 1, 5'd7,  1, 0, 1, 5'd7};
        tbl[9]  = '{1, 32'h20090001, 0, 5'd0,  1, 0, 1, 5'd9};
        tbl[10] = '{1, 32'h20090001, 1, 5'd9,  1, 0, 1, 5'd9};
        tbl[11] = '{0, 32'h00000000, 1, 5'd0,  0, 0, 0, 5'd0};
        tbl[12] = '{0, 32'h00000000, 1, 5'd10, 0, 0, 0, 5'd0};
        tbl[13] = '{1, 32'h00C00008, 0, 5'd0,  0, 1, 0, 5'd0};
        tbl[14] = '{1, 32'h00C00008, 1, 5'd6,  1, 0, 0, 5'd0};
        tbl[15] = '{1, 32'h3C000005, 0, 5'd0,  1, 0, 0, 5'd0};
        tbl[16] = '{1, 32'hACA90000, 0, 5'd0,  0, 1, 0, 5'd0};
        tbl[17] = '{1, 32'h0C000000, 0, 5'd0,  1, 0, 1, 5'd31};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].ins, tbl[i].wv, tbl[i].wr, 1'b0, ai, as, aw, ad);
            chk($sformatf("tbl%0d_issue", i), ai, tbl[i].e_issue);
            chk($sformatf("tbl%0d_stall", i), as, tbl[i].e_stall);
            chk($sformatf("tbl%0d_we", i), aw, tbl[i].e_we);
            if (tbl[i].e_we) chk($sformatf("tbl%0d_dest", i), ad, tbl[i].e_dest);
        end
        chk("tbl_pending", pending, 32'h80000280);
        chk("tbl_stall_count", stall_count, 5);

        step(1, 32'hACA90000, 0, 0, 0, ai, as, aw, ad);
        chk("redir_pre_stall", as, 1);
        step(1, 32'hACA90000, 0, 0, 1, ai, as, aw, ad);
        chk("redir_issue0", ai, 0);
        chk("redir_stall0", as, 0);
        step(1, 32'h20010001, 0, 0, 0, ai, as, aw, ad);
        chk("flush_issue", ai, 0);
        chk("flush_stall", as, 0);
        chk("flush_pending", pending, 32'h80000280);
        step(1, 32'h20010001, 0, 0, 0, ai, as, aw, ad);
        chk("post_flush_issue", ai, 1);

        id_valid = 1'b1; id_instr = 32'hACA90000; wb_valid = 1'b0; redirect = 1'b0;
        #1;
        chk("pre_rst_stall", id_stall, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_issue", id_issue, 0);
        chk("arst_stall", id_stall, 0);
        chk("arst_dest_we", dest_we, 0);
        chk("arst_pending", pending, 0);
        chk("arst_stall_count", stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 32'h20050001, 0, 0, 0, ai, as, aw, ad);
        chk("post_rst_issue", ai, 1);

        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0F, 6'h02, 6'h03, 6'h0D, 6'h3F};
        for (int k = 0; k < 400; k++) begin
            op = ops[$urandom_range(0, 9)];
            step($urandom_range(0, 4) != 0,
                 {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'd0, ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20},
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
                 ai, as, aw, ad);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
